// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for the 5-stage pipeline.
// Resolves load-use, EX redirects and MEM ready/ack waits.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_re,
  input  logic             id_rs2_re,
  input  logic [4:0]       ex_wr,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dram_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] TO = W'(MEM_TIMEOUT);
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {
    S_RUN,
    S_MEMWAIT
  } state_t;

  state_t       state;
  logic [W-1:0] wait_cnt;

  logic mem_stall;
  logic timeout;
  logic lu_hit;
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_re & (id_rs1 == ex_wr);
  assign rs2_hit = id_rs2_re & (id_rs2 == ex_wr);
  assign lu_hit  = ex_is_load & ex_rf_we
                 & (ex_wr != 5'd0)
                 & (rs1_hit | rs2_hit);

  always_comb begin
    mem_stall = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      S_RUN: mem_stall = mem_req & ~dram_ack;
      S_MEMWAIT: begin
        mem_stall = mem_req & ~dram_ack
                  & (wait_cnt != TO);
        timeout   = mem_req & ~dram_ack
                  & (wait_cnt == TO);
      end
      default: mem_stall = 1'b0;
    endcase
  end

  // EX is frozen during a mem stall, so redirect
  // and load-use are deferred until release.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    unique case (1'b1)
      mem_stall: begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      (!mem_stall && ex_redirect): begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      (!mem_stall && !ex_redirect && lu_hit): begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: pc_stall = 1'b0;
    endcase
  end

  assign mem_err = timeout & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (mem_req && !dram_ack) begin
            state    <= S_MEMWAIT;
            wait_cnt <= ONE;
          end
        end
        S_MEMWAIT: begin
          if (dram_ack || !mem_req
              || wait_cnt == TO) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + ONE;
          end
        end
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
